dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate data-cache controller that acts as the initiator toward the 32-entry tag SRAM and the 32-line data SRAM, with a combinational read and a negedge write on each. It accepts single-word CPU requests, stalls the CPU on a miss, writes back dirty victims, refills 256-bit lines from memory, and clears all tags after reset. It sits between the CPU memory stage and the off-chip memory model.

## Interface
- No parameters. Address split: tag = addr[31:10] (22 b), index = addr[9:5], word = addr[4:2]; line = 256 b (8 words).
- Tag entry (24 b): bit 23 valid, bit 22 dirty, bits 21:0 tag.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- p1_req_i  in  1  CPU request valid.
- p1_write_i  in  1  1 = store, 0 = load.
- p1_addr_i  in  32  byte address (bits 1:0 ignored).
- p1_data_i  in  32  store data.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  CPU must hold its request.
- tag_enable_o / tag_write_o  out  1 / 1  tag SRAM enable / write.
- tag_addr_o  out  5  tag SRAM index.
- tag_data_o  out  24  tag write data.
- tag_data_i  in  24  tag read data (combinational).
- data_enable_o / data_write_o  out  1 / 1  data SRAM enable / write.
- data_addr_o  out  5  data SRAM index.
- data_data_o  out  256  line write data.
- data_data_i  in  256  line read data (combinational).
- mem_enable_o / mem_write_o  out  1 / 1  memory request / direction.
- mem_addr_o  out  32  line-aligned memory address (bits 4:0 = 0).
- mem_data_o  out  256  writeback line.
- mem_data_i  in  256  refill line.
- mem_ack_i  in  1  one-cycle completion pulse from memory.

## Operation
- States: INIT, IDLE, WRITEBACK, ALLOCATE, REFILL.
- INIT: a 5-bit counter sweeps indices 0..31, one per cycle, with tag_enable_o = tag_write_o = 1 and tag_data_o = 0. After index 31 it moves to IDLE. p1_stall_o = 1 throughout.
- IDLE: tag/data enables = p1_req_i, and addresses = index. hit = p1_req_i & tag_data_i[23] & (tag_data_i[21:0] == tag).
- Load hit: p1_data_o = data_data_i word[word], p1_stall_o = 0, no writes.
- Store hit: data_data_o = data_data_i with word[word] replaced by p1_data_i, and data_write_o = 1. tag_data_o = {1,1,tag} and tag_write_o = 1. p1_stall_o = 0.
- Miss: p1_stall_o = 1. The victim is the tag_data_i entry. If victim valid & dirty, go to WRITEBACK and latch mem_data_o = data_data_i and mem_addr_o = {victim tag, index, 5'b0}. Otherwise go to ALLOCATE.
- WRITEBACK: mem_enable_o = 1 and mem_write_o = 1, held steady until the cycle with mem_ack_i = 1, then go to ALLOCATE.
- ALLOCATE: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0}, held until mem_ack_i. On the ack cycle, latch mem_data_i and go to REFILL.
- REFILL: data_write_o = 1 with the latched line, and tag_write_o = 1 with {1,0,tag}. mem_enable_o = 0. Then go to IDLE, where the held request hits and completes.
- The CPU must keep p1_req_i, p1_addr_i, p1_write_i and p1_data_i stable while p1_stall_o = 1. The controller uses the live inputs for index and tag in every state.
- mem_ack_i is ignored in INIT, IDLE and REFILL.
- Reset values: all enables and writes = 0, mem_addr_o = 0, mem_data_o = 0, p1_data_o = 0. p1_stall_o = 1 while rst_i is high, because the state is INIT.

## Timing
- Hit: zero added latency. Result and write strobes are valid in the request cycle. SRAM writes commit on that cycle's negedge.
- Clean miss: stall from request cycle T. ALLOCATE runs from T+1. If ack arrives at cycle A, REFILL is at A+1 and the hit completes at A+2.
- Dirty miss: WRITEBACK runs from T+1 to ack W. ALLOCATE runs from W+1 to ack A, REFILL is at A+1, and the hit completes at A+2.
- Ack in the first cycle of a memory state is legal and gives a 1-cycle state.
- rst_i high in any state: next state is INIT with the counter at 0. mem_enable_o drops the next cycle, an in-flight memory transaction is abandoned, and no SRAM write occurs in that cycle.
- INIT always lasts 32 cycles after rst_i deasserts.

## Test plan
- Reset, then idle: p1_stall_o = 1 for 32 cycles, tag_write_o = 1 with tag_addr_o = 0..31 and tag_data_o = 0, then p1_stall_o = 0.
- Load 0x0000_0404 after init: clean miss. mem_addr_o = 0x0000_0400 and mem_write_o = 0. Ack with line word1 = 0xDEADBEEF. REFILL writes tag {1,0,0x000001}. Next cycle p1_data_o = 0xDEADBEEF, stall = 0.
- Store 0x1234_5678 to 0x0000_0404 (hit): same-cycle data write replaces word1 only, tag written {1,1,0x000001}, stall = 0.
- Load 0x0000_0804 (same index 0, dirty victim): WRITEBACK with mem_addr_o = 0x0000_0400 and mem_data_o word1 = 0x12345678. Then ALLOCATE with mem_addr_o = 0x0000_0800, then REFILL, then hit.
- Delay mem_ack_i by 5 cycles in ALLOCATE: mem_enable_o, mem_addr_o and p1_stall_o stay constant for 6 cycles, and a spurious ack in IDLE has no effect.
- Assert rst_i during WRITEBACK: next cycle mem_enable_o = 0, state INIT, and the 32-cycle tag clear repeats.

Source files
------------

// File: rtl/dcache_controller_if.sv
// Signal bundle between the data-cache controller, the CPU memory stage,
// the tag/data SRAMs and the off-chip memory model.
interface dcache_controller_if;
   logic         p1_req_i;
   logic         p1_write_i;
   logic [31:0]  p1_addr_i;
   logic [31:0]  p1_data_i;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;

   logic         tag_enable_o;
   logic         tag_write_o;
   logic [4:0]   tag_addr_o;
   logic [23:0]  tag_data_o;
   logic [23:0]  tag_data_i;

   logic         data_enable_o;
   logic         data_write_o;
   logic [4:0]   data_addr_o;
   logic [255:0] data_data_o;
   logic [255:0] data_data_i;

   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   // Controller side.
   modport master (
      input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
      output p1_data_o, p1_stall_o,
      output tag_enable_o, tag_write_o, tag_addr_o, tag_data_o,
      input  tag_data_i,
      output data_enable_o, data_write_o, data_addr_o, data_data_o,
      input  data_data_i,
      output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i
   );

   // CPU, SRAM and memory side.
   modport slave (
      output p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
      input  p1_data_o, p1_stall_o,
      input  tag_enable_o, tag_write_o, tag_addr_o, tag_data_o,
      output tag_data_i,
      input  data_enable_o, data_write_o, data_addr_o, data_data_o,
      output data_data_i,
      input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i
   );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back / write-allocate data-cache controller: single-word
// CPU port, 32 x 256-bit lines, tag clear after reset, dirty writeback, refill.
module dcache_controller (
   input  logic                clk_i,
   input  logic                rst_i,
   dcache_controller_if.master bus
);
   typedef enum logic [2:0] {INIT, IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

   state_t       state, state_next;
   logic [4:0]   init_cnt;
   logic [31:0]  mem_addr_q;
   logic [255:0] wb_line_q;
   logic [255:0] refill_line_q;

   logic [21:0]  req_tag;
   logic [4:0]   req_index;
   logic [2:0]   req_word;
   logic         hit;
   logic         victim_dirty;
   logic [255:0] store_line;

   logic         stall;
   logic         tag_en, tag_we, data_en, data_we, mem_en, mem_we;
   logic [4:0]   tag_addr;
   logic [23:0]  tag_wdata;
   logic [255:0] data_wdata;

   logic         unused_addr_bits;
   assign unused_addr_bits = ^bus.p1_addr_i[1:0];

   assign req_tag      = bus.p1_addr_i[31:10];
   assign req_index    = bus.p1_addr_i[9:5];
   assign req_word     = bus.p1_addr_i[4:2];
   assign hit          = bus.p1_req_i & bus.tag_data_i[23] & (bus.tag_data_i[21:0] == req_tag);
   assign victim_dirty = bus.tag_data_i[23] & bus.tag_data_i[22];

   always_comb begin
      store_line = bus.data_data_i;
      store_line[{req_word, 5'd0} +: 32] = bus.p1_data_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= INIT;
         init_cnt   <= 5'd0;
         mem_addr_q <= 32'd0;
         wb_line_q  <= 256'd0;
      end else begin
         state <= state_next;
         if (state == INIT) init_cnt <= init_cnt + 5'd1;
         case (state)
            IDLE: begin
               if (bus.p1_req_i && !hit) begin
                  if (victim_dirty) begin
                     mem_addr_q <= {bus.tag_data_i[21:0], req_index, 5'd0};
                     wb_line_q  <= bus.data_data_i;
                  end else begin
                     mem_addr_q <= {req_tag, req_index, 5'd0};
                  end
               end
            end
            WRITEBACK: if (bus.mem_ack_i) mem_addr_q <= {req_tag, req_index, 5'd0};
            default: ;
         endcase
      end
   end

   // NOTE: the refill buffer is pure datapath, always written before it is
   // read, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (state == ALLOCATE && bus.mem_ack_i) refill_line_q <= bus.mem_data_i;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_next = state;
      stall      = 1'b1;
      tag_en     = 1'b0;
      tag_we     = 1'b0;
      tag_addr   = req_index;
      tag_wdata  = 24'd0;
      data_en    = 1'b0;
      data_we    = 1'b0;
      data_wdata = 256'd0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      case (state)
         INIT: begin
            tag_en   = 1'b1;
            tag_we   = 1'b1;
            tag_addr = init_cnt;
            if (init_cnt == 5'd31) state_next = IDLE;
         end
         IDLE: begin
            tag_en  = bus.p1_req_i;
            data_en = bus.p1_req_i;
            stall   = bus.p1_req_i & ~hit;
            if (hit && bus.p1_write_i) begin
               data_we    = 1'b1;
               data_wdata = store_line;
               tag_we     = 1'b1;
               tag_wdata  = {2'b11, req_tag};
            end else if (bus.p1_req_i && !hit) begin
               state_next = victim_dirty ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            if (bus.mem_ack_i) state_next = ALLOCATE;
         end
         ALLOCATE: begin
            mem_en = 1'b1;
            if (bus.mem_ack_i) state_next = REFILL;
         end
         REFILL: begin
            tag_en     = 1'b1;
            tag_we     = 1'b1;
            tag_wdata  = {2'b10, req_tag};
            data_en    = 1'b1;
            data_we    = 1'b1;
            data_wdata = refill_line_q;
            state_next = IDLE;
         end
         default: state_next = INIT;
      endcase
      // A reset cycle never commits an SRAM write, whatever state it interrupts.
      if (rst_i) begin
         tag_en  = 1'b0;
         tag_we  = 1'b0;
         data_en = 1'b0;
         data_we = 1'b0;
      end
   end

   assign bus.p1_stall_o    = stall;
   assign bus.p1_data_o     = (state == IDLE && hit && !bus.p1_write_i) ?
                              bus.data_data_i[{req_word, 5'd0} +: 32] : 32'd0;
   assign bus.tag_enable_o  = tag_en;
   assign bus.tag_write_o   = tag_we;
   assign bus.tag_addr_o    = tag_addr;
   assign bus.tag_data_o    = tag_wdata;
   assign bus.data_enable_o = data_en;
   assign bus.data_write_o  = data_we;
   assign bus.data_addr_o   = req_index;
   assign bus.data_data_o   = data_wdata;
   assign bus.mem_enable_o  = mem_en;
   assign bus.mem_write_o   = mem_we;
   assign bus.mem_addr_o    = mem_addr_q;
   assign bus.mem_data_o    = wb_line_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: SRAM and memory models, a cache
// model for expected miss behaviour, and a load-data scoreboard queue.
module tb_dcache_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dcache_controller_if bus ();
   dcache_controller dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   logic [23:0]  tag_mem  [32];
   logic [255:0] data_mem [32];
   assign bus.tag_data_i  = tag_mem[bus.tag_addr_o];
   assign bus.data_data_i = data_mem[bus.data_addr_o];
   always @(negedge clk) begin
      if (bus.tag_enable_o && bus.tag_write_o)   tag_mem[bus.tag_addr_o]   <= bus.tag_data_o;
      if (bus.data_enable_o && bus.data_write_o) data_mem[bus.data_addr_o] <= bus.data_data_o;
   end

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] mem_words [logic [31:0]];
   logic [31:0] ref_words [logic [31:0]];
   bit          c_valid [32];
   bit          c_dirty [32];
   logic [21:0] c_tag   [32];

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_get(input logic [31:0] a);
      return mem_words.exists(a) ? mem_words[a] : (a ^ 32'h5A5A_C3C3);
   endfunction

   function automatic logic [31:0] ref_get(input logic [31:0] a);
      return ref_words.exists(a) ? ref_words[a] : mem_get(a);
   endfunction

   function automatic logic [255:0] mem_line(input logic [31:0] base);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_get(base + 32'(w*4));
      return l;
   endfunction

   function automatic logic [255:0] ref_line(input logic [31:0] base);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_get(base + 32'(w*4));
      return l;
   endfunction

   task automatic do_reset(input int n);
      rst = 1'b1;
      bus.p1_req_i = 1'b0;
      bus.mem_ack_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #2;
         check("rst_stall", bus.p1_stall_o, 1);
         check("rst_tag_we", bus.tag_write_o, 0);
         check("rst_data_we", bus.data_write_o, 0);
         check("rst_mem_en", bus.mem_enable_o, 0);
         check("rst_mem_addr", bus.mem_addr_o, 0);
         check("rst_p1_data", bus.p1_data_o, 0);
      end
      for (int i = 0; i < 32; i++) begin
         c_valid[i] = 1'b0;
         c_dirty[i] = 1'b0;
      end
      ref_words.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) begin
         check("init_tag_we", bus.tag_write_o, 1);
         check("init_tag_addr", bus.tag_addr_o, i);
         check("init_tag_data", bus.tag_data_o, 0);
         check("init_stall", bus.p1_stall_o, 1);
         bus.mem_ack_i = (i == 10);
         @(posedge clk); #2;
      end
      bus.mem_ack_i = 1'b0;
      check("init_done_stall", bus.p1_stall_o, 0);
      check("init_done_tag_we", bus.tag_write_o, 0);
   endtask

   task automatic cpu_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input int delay);
      logic [21:0]  tg = addr[31:10];
      logic [4:0]   idx = addr[9:5];
      logic [31:0]  base = {addr[31:5], 5'd0};
      logic [31:0]  vbase = {c_tag[idx], idx, 5'd0};
      bit           was_hit = c_valid[idx] && (c_tag[idx] == tg);
      bit           in_wb = !was_hit && c_valid[idx] && c_dirty[idx];
      int           exp_cyc = was_hit ? 0 : (in_wb ? 2*delay + 4 : delay + 3);
      bit           refill_pending = 1'b0;
      bit           done = 1'b0;
      int           wait_n = 0;
      int           cyc = 0;
      logic [255:0] refill_line, exp_line;
      bus.p1_req_i   = 1'b1;
      bus.p1_write_i = wr;
      bus.p1_addr_i  = addr;
      bus.p1_data_i  = wdata;
      if (!wr) exp_q.push_back(ref_get({addr[31:2], 2'b00}));
      #1;
      while (!done && cyc < 100) begin
         if (!bus.p1_stall_o) begin
            done = 1'b1;
            check("latency", cyc, exp_cyc);
            if (wr) begin
               exp_line = ref_line(base);
               exp_line[{addr[4:2], 5'd0} +: 32] = wdata;
               check("st_data_we", bus.data_write_o, 1);
               check("st_line", bus.data_data_o, exp_line);
               check("st_tag_we", bus.tag_write_o, 1);
               check("st_tag", bus.tag_data_o, {2'b11, tg});
            end else begin
               check("ld_data_we", bus.data_write_o, 0);
               check("ld_tag_we", bus.tag_write_o, 0);
               if (exp_q.size() == 0) check("sb_underflow", 1, 0);
               else check("ld_data", bus.p1_data_o, exp_q.pop_front());
            end
         end else if (bus.mem_enable_o) begin
            check(in_wb ? "wb_addr" : "alloc_addr", bus.mem_addr_o, in_wb ? vbase : base);
            check("mem_dir", bus.mem_write_o, in_wb);
            if (in_wb) check("wb_line", bus.mem_data_o, ref_line(vbase));
            if (wait_n == delay) begin
               if (in_wb) begin
                  for (int w = 0; w < 8; w++) mem_words[vbase + 32'(w*4)] = bus.mem_data_o[w*32 +: 32];
               end else begin
                  refill_line = mem_line(base);
                  bus.mem_data_i = refill_line;
                  refill_pending = 1'b1;
               end
               bus.mem_ack_i = 1'b1;
               wait_n = 0;
               in_wb = 1'b0;
            end else begin
               wait_n++;
            end
         end else if (refill_pending) begin
            check("rf_data_we", bus.data_write_o, 1);
            check("rf_line", bus.data_data_o, refill_line);
            check("rf_tag_we", bus.tag_write_o, 1);
            check("rf_tag", bus.tag_data_o, {2'b10, tg});
            refill_pending = 1'b0;
         end
         if (!done) begin
            @(posedge clk); #1;
            bus.mem_ack_i = 1'b0;
            #1;
            cyc++;
         end
      end
      if (!done) check("timeout", 0, 1);
      @(posedge clk); #1;
      bus.p1_req_i = 1'b0;
      c_valid[idx] = 1'b1;
      c_tag[idx]   = tg;
      if (!was_hit) c_dirty[idx] = 1'b0;
      if (wr) begin
         c_dirty[idx] = 1'b1;
         ref_words[{addr[31:2], 2'b00}] = wdata;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int n;
      bus.p1_req_i = 1'b0;
      bus.p1_write_i = 1'b0;
      bus.p1_addr_i = 32'd0;
      bus.p1_data_i = 32'd0;
      bus.mem_data_i = 256'd0;
      bus.mem_ack_i = 1'b0;
      mem_words[32'h0000_0404] = 32'hDEAD_BEEF;

      do_reset(3);
      cpu_access(1'b0, 32'h0000_0404, 32'd0, 0);
      cpu_access(1'b1, 32'h0000_0404, 32'h1234_5678, 0);
      cpu_access(1'b0, 32'h0000_0404, 32'd0, 0);
      cpu_access(1'b0, 32'h0000_0804, 32'd0, 0);
      cpu_access(1'b0, 32'h0000_1008, 32'd0, 5);

      // An ack while idle must not start or disturb anything.
      bus.mem_ack_i = 1'b1;
      #1;
      check("spur_stall", bus.p1_stall_o, 0);
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      #1;
      check("spur_mem_en", bus.mem_enable_o, 0);
      check("spur_stall2", bus.p1_stall_o, 0);
      #4;
      cpu_access(1'b0, 32'h0000_1008, 32'd0, 0);

      cpu_access(1'b1, 32'hFFFF_FFFC, 32'hA5A5_0F0F, 1);
      cpu_access(1'b0, 32'hFFFF_FFFC, 32'd0, 0);
      cpu_access(1'b0, 32'h0000_03FC, 32'd0, 2);

      for (int i = 0; i < 24; i++) begin
         a = 32'd0;
         a[31:10] = 22'($urandom_range(0, 3));
         a[9:5]   = 5'($urandom_range(0, 3));
         a[4:2]   = 3'($urandom_range(0, 7));
         cpu_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
      end

      // Reset in the middle of a dirty writeback abandons it.
      cpu_access(1'b1, 32'h0000_0020, 32'hCAFE_0001, 0);
      bus.p1_req_i = 1'b1;
      bus.p1_write_i = 1'b0;
      bus.p1_addr_i = 32'h0000_0420;
      exp_q.push_back(32'd0);
      n = 0;
      #1;
      while (!(bus.mem_enable_o && bus.mem_write_o) && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      check("wb_reached", bus.mem_enable_o && bus.mem_write_o, 1);
      void'(exp_q.pop_back());
      rst = 1'b1;
      do_reset(2);
      cpu_access(1'b0, 32'h0000_0020, 32'd0, 0);
      cpu_access(1'b0, 32'h0000_0420, 32'd0, 1);

      check("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
